rotor_stage: RTL and testbench

ROTOR_STAGE -- requirements
Module: rotor_stage

---
 rtl/rotor_stage_if.sv | 23 ++
 rtl/rotor_stage.sv | 153 +++++++++++++++
 tb/tb_rotor_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotor_stage_if.sv
// Symbol stream bundle for a rotor stage: upstream symbol handshake plus
// downstream encoded-symbol handshake with its error flag.
interface rotor_stage_if #(
    parameter int WIDTH = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/rotor_stage.sv
// One rotor of a rotor cipher: programmable wiring table, stepping position
// with notch carry, and a two-stage valid/ready substitution pipeline.
module rotor_stage #(
    parameter int ALPHABET = 26,
    parameter int WIDTH    = 5,
    parameter int REVERSE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             pos_load,
    input  logic [WIDTH-1:0] pos_value,
    input  logic             step_in,
    input  logic [WIDTH-1:0] notch_pos,
    input  logic [WIDTH-1:0] ring_position,
    rotor_stage_if.slave     bus,
    output logic [WIDTH-1:0] position,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0]        LAST    = WIDTH'(ALPHABET - 1);
    localparam logic signed [WIDTH+1:0] ALPHA_S = (WIDTH+2)'(ALPHABET);

    function automatic logic in_range(input logic [WIDTH-1:0] v);
        return v <= LAST;
    endfunction

    function automatic logic signed [WIDTH+1:0] widen(input logic [WIDTH-1:0] v);
        return signed'({2'b00, v});
    endfunction

    // Operands are all below ALPHABET, so one correction step always lands in range.
    function automatic logic [WIDTH-1:0] wrap(input logic signed [WIDTH+1:0] v);
        logic signed [WIDTH+1:0] r;
        r = v;
        if (r[WIDTH+1]) begin
            r = r + ALPHA_S;
        end else if (r >= ALPHA_S) begin
            r = r - ALPHA_S;
        end
        return r[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] fwd_tbl [ALPHABET];
    logic [WIDTH-1:0] rev_tbl [ALPHABET];

    logic             cfg_ok;
    logic [WIDTH-1:0] pos_next;

    logic             s1_valid;
    logic             s1_err;
    logic [WIDTH-1:0] s1_sym;
    logic [WIDTH-1:0] s1_ring;
    logic [WIDTH-1:0] s1_pos;

    logic             s2_valid;
    logic             s2_err;
    logic [WIDTH-1:0] s2_data;

    logic             s2_free;
    logic             accept;
    logic             in_err;
    logic [WIDTH-1:0] lookup_idx;
    logic [WIDTH-1:0] lookup_val;
    logic [WIDTH-1:0] s2_result;

    assign cfg_ok = cfg_we && in_range(cfg_addr) && in_range(cfg_data);

    // Both directions are kept so either wiring path can be selected per instance.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ALPHABET; i++) begin
                fwd_tbl[i] <= WIDTH'(i);
                rev_tbl[i] <= WIDTH'(i);
            end
        end else if (cfg_ok) begin
            fwd_tbl[cfg_addr] <= cfg_data;
            rev_tbl[cfg_data] <= cfg_addr;
        end
    end

    assign pos_next = (position == LAST) ? '0 : position + 1'b1;

    // A load request always beats a step, even when the loaded value is rejected.
    always_ff @(posedge clk) begin
        if (reset) begin
            position  <= '0;
            carry_out <= 1'b0;
        end else if (pos_load) begin
            if (in_range(pos_value)) begin
                position <= pos_value;
            end
            carry_out <= 1'b0;
        end else if (step_in) begin
            position  <= pos_next;
            carry_out <= (position == notch_pos);
        end else begin
            carry_out <= 1'b0;
        end
    end

    assign s2_free      = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_free;
    assign accept       = bus.in_valid && bus.in_ready;

    assign in_err     = !in_range(bus.in_data) || !in_range(ring_position) || !in_range(position);
    assign lookup_idx = in_err ? '0
                               : wrap(widen(bus.in_data) - widen(ring_position) + widen(position));
    assign lookup_val = (REVERSE != 0) ? rev_tbl[lookup_idx] : fwd_tbl[lookup_idx];

    // Ring and position travel with the symbol so later rotor motion cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_sym   <= '0;
            s1_ring  <= '0;
            s1_pos   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_err   <= in_err;
            s1_sym   <= in_err ? bus.in_data : lookup_val;
            s1_ring  <= ring_position;
            s1_pos   <= position;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    assign s2_result = s1_err ? s1_sym
                              : wrap(widen(s1_sym) + widen(s1_ring) - widen(s1_pos));

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_data  <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_err  <= s1_err;
                s2_data <= s2_result;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_err   = s2_err;

endmodule

// File: tb/tb_rotor_stage.sv
// Scoreboard bench for rotor_stage: forward and inverse instances driven in
// lockstep, checked against an arithmetic reference model of the rotor.
module tb_rotor_stage;

    localparam int ALPHABET = 26;
    localparam int WIDTH    = 5;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic             pos_load;
    logic [WIDTH-1:0] pos_value;
    logic             step_in;
    logic [WIDTH-1:0] notch_pos;
    logic [WIDTH-1:0] ring_position;
    logic [WIDTH-1:0] position_fwd;
    logic [WIDTH-1:0] position_rev;
    logic             carry_fwd;
    logic             carry_rev;

    rotor_stage_if #(.WIDTH(WIDTH)) bus_fwd ();
    rotor_stage_if #(.WIDTH(WIDTH)) bus_rev ();

    rotor_stage #(.ALPHABET(ALPHABET), .WIDTH(WIDTH), .REVERSE(0)) dut_fwd (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pos_load(pos_load), .pos_value(pos_value), .step_in(step_in), .notch_pos(notch_pos),
        .ring_position(ring_position), .bus(bus_fwd), .position(position_fwd), .carry_out(carry_fwd)
    );

    rotor_stage #(.ALPHABET(ALPHABET), .WIDTH(WIDTH), .REVERSE(1)) dut_rev (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pos_load(pos_load), .pos_value(pos_value), .step_in(step_in), .notch_pos(notch_pos),
        .ring_position(ring_position), .bus(bus_rev), .position(position_rev), .carry_out(carry_rev)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    bit p_reset, p_cfg_we, p_pos_load, p_step, p_valid, p_out_ready;
    int p_cfg_addr, p_cfg_data, p_pos_value, p_notch, p_ring, p_data;
    int ovr_fwd = -1;
    int ovr_rev = -1;
    bit last_accepted;

    int   fwd_m [ALPHABET];
    int   rev_m [ALPHABET];
    int   pos_m;
    exp_t q_fwd [$];
    exp_t q_rev [$];
    bit   stall [2];
    exp_t held  [2];

    string rotor_i = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

    task automatic checkVal(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ALPHABET; i++) begin
            fwd_m[i] = i;
            rev_m[i] = i;
        end
        pos_m = 0;
    endtask

    function automatic int modAlpha(input int v);
        return ((v % ALPHABET) + ALPHABET) % ALPHABET;
    endfunction

    function automatic exp_t modelOut(input int d, input int ring, input int pos, input bit inverse);
        exp_t e;
        int   t;
        if (d >= ALPHABET || ring >= ALPHABET || pos >= ALPHABET) begin
            e.data = WIDTH'(d);
            e.err  = 1'b1;
        end else begin
            t      = inverse ? rev_m[modAlpha(d - ring + pos)] : fwd_m[modAlpha(d - ring + pos)];
            e.data = WIDTH'(modAlpha(t + ring - pos));
            e.err  = 1'b0;
        end
        return e;
    endfunction

    // Hand-derived constants: anything at or above ALPHABET can only be a pass-through error.
    function automatic exp_t fixedExp(input int v);
        exp_t e;
        e.data = WIDTH'(v);
        e.err  = (v >= ALPHABET);
        return e;
    endfunction

    task automatic cycleStep();
        bit carry_exp;
        @(negedge clk);
        reset            = p_reset;
        cfg_we           = p_cfg_we;
        cfg_addr         = WIDTH'(p_cfg_addr);
        cfg_data         = WIDTH'(p_cfg_data);
        pos_load         = p_pos_load;
        pos_value        = WIDTH'(p_pos_value);
        step_in          = p_step;
        notch_pos        = WIDTH'(p_notch);
        ring_position    = WIDTH'(p_ring);
        bus_fwd.in_valid  = p_valid;
        bus_fwd.in_data   = WIDTH'(p_data);
        bus_fwd.out_ready = p_out_ready;
        bus_rev.in_valid  = p_valid;
        bus_rev.in_data   = WIDTH'(p_data);
        bus_rev.out_ready = p_out_ready;
        #1;
        last_accepted = !p_reset && p_valid && bus_fwd.in_ready;
        carry_exp = 1'b0;
        if (p_reset) begin
            modelReset();
            q_fwd.delete();
            q_rev.delete();
        end else begin
            if (last_accepted) begin
                q_fwd.push_back(ovr_fwd >= 0 ? fixedExp(ovr_fwd) : modelOut(p_data, p_ring, pos_m, 1'b0));
                q_rev.push_back(ovr_rev >= 0 ? fixedExp(ovr_rev) : modelOut(p_data, p_ring, pos_m, 1'b1));
            end
            if (p_pos_load) begin
                if (p_pos_value < ALPHABET) pos_m = p_pos_value;
            end else if (p_step) begin
                carry_exp = (pos_m == p_notch);
                pos_m     = (pos_m + 1) % ALPHABET;
            end
            if (p_cfg_we && p_cfg_addr < ALPHABET && p_cfg_data < ALPHABET) begin
                fwd_m[p_cfg_addr] = p_cfg_data;
                rev_m[p_cfg_data] = p_cfg_addr;
            end
        end
        @(posedge clk);
        #1;
        checkVal("position_fwd", int'(position_fwd), pos_m);
        checkVal("position_rev", int'(position_rev), pos_m);
        checkVal("carry_fwd", int'(carry_fwd), int'(carry_exp));
        checkVal("carry_rev", int'(carry_rev), int'(carry_exp));
        p_cfg_we   = 1'b0;
        p_pos_load = 1'b0;
        p_step     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycleStep();
    endtask

    task automatic applyStimulus(input int d, input int e_fwd, input int e_rev);
        p_valid = 1'b1;
        p_data  = d;
        ovr_fwd = e_fwd;
        ovr_rev = e_rev;
        for (int n = 0; n < 50; n++) begin
            cycleStep();
            if (last_accepted) break;
        end
        if (!last_accepted) checkVal("accept_timeout", 0, 1);
        p_valid = 1'b0;
        ovr_fwd = -1;
        ovr_rev = -1;
    endtask

    task automatic doReset();
        p_reset = 1'b1;
        cycleStep();
        p_reset = 1'b0;
        checkVal("reset_out_valid", int'(bus_fwd.out_valid), 0);
        checkVal("reset_out_data", int'(bus_fwd.out_data), 0);
        checkVal("reset_out_err", int'(bus_fwd.out_err), 0);
        cycleStep();
        checkVal("reset_in_ready", int'(bus_fwd.in_ready), 1);
    endtask

    task automatic writeCfg(input int a, input int d);
        p_cfg_we   = 1'b1;
        p_cfg_addr = a;
        p_cfg_data = d;
        cycleStep();
    endtask

    task automatic loadRotorI();
        for (int i = 0; i < ALPHABET; i++) writeCfg(i, int'(rotor_i[i]) - 65);
    endtask

    task automatic loadPos(input int v);
        p_pos_load  = 1'b1;
        p_pos_value = v;
        cycleStep();
    endtask

    task automatic checkOutput(input bit inv, input logic v, input logic r,
                               input logic [WIDTH-1:0] d, input logic e);
        exp_t  want;
        string side;
        side = inv ? "rev" : "fwd";
        if (stall[inv]) begin
            checkVal({"hold_", side}, int'({v, d, e}), int'({1'b1, held[inv]}));
        end
        if (v && r) begin
            if ((inv ? q_rev.size() : q_fwd.size()) == 0) begin
                checkVal({"spurious_out_", side}, 1, 0);
            end else begin
                want = inv ? q_rev.pop_front() : q_fwd.pop_front();
                checkVal({"out_data_", side}, int'(d), int'(want.data));
                checkVal({"out_err_", side}, int'(e), int'(want.err));
            end
        end
        stall[inv] = v && !r;
        held[inv]  = {d, e};
    endtask

    // Monitor samples mid-low-phase, after the driver has settled this cycle's inputs.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            checkOutput(1'b0, bus_fwd.out_valid, bus_fwd.out_ready, bus_fwd.out_data, bus_fwd.out_err);
            checkOutput(1'b1, bus_rev.out_valid, bus_rev.out_ready, bus_rev.out_data, bus_rev.out_err);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        p_reset = 1'b1; p_cfg_we = 1'b0; p_pos_load = 1'b0; p_step = 1'b0;
        p_valid = 1'b0; p_out_ready = 1'b1;
        p_cfg_addr = 0; p_cfg_data = 0; p_pos_value = 0; p_notch = 16; p_ring = 0; p_data = 0;
        reset = 1'b1;
        modelReset();
        doReset();

        // Identity wiring straight out of reset.
        applyStimulus(7, 7, 7);
        idle(3);

        loadRotorI();
        applyStimulus(0, 4, -1);
        idle(2);
        loadPos(1);
        applyStimulus(0, 9, -1);
        loadPos(0);
        p_ring = 1;
        applyStimulus(0, 10, -1);
        p_ring = 0;
        applyStimulus(4, -1, 0);
        idle(3);

        // Table write racing a lookup must not affect that lookup.
        p_cfg_we = 1'b1; p_cfg_addr = 0; p_cfg_data = 5;
        applyStimulus(0, 4, -1);
        writeCfg(0, 4);
        writeCfg(3, 5);
        applyStimulus(3, 5, -1);
        idle(3);

        p_notch = 16;
        loadPos(16);
        p_step = 1'b1;
        cycleStep();
        idle(1);
        loadPos(25);
        p_step = 1'b1;
        cycleStep();
        loadPos(16);
        p_pos_load = 1'b1; p_pos_value = 3; p_step = 1'b1;
        cycleStep();
        loadPos(30);
        loadPos(0);

        // Backpressure: two symbols fill the pipe, the third must wait.
        p_out_ready = 1'b0;
        applyStimulus(0, 4, -1);
        applyStimulus(1, 10, -1);
        p_valid = 1'b1; p_data = 2; ovr_fwd = 12; ovr_rev = -1;
        for (int i = 0; i < 3; i++) begin
            cycleStep();
            checkVal("in_ready_full", int'(bus_fwd.in_ready), 0);
        end
        p_out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycleStep();
            if (last_accepted) break;
        end
        if (!last_accepted) checkVal("accept_timeout", 0, 1);
        p_valid = 1'b0; ovr_fwd = -1;
        idle(4);

        applyStimulus(27, 27, 27);
        idle(3);

        // Reset with two symbols in flight: nothing may emerge afterwards.
        p_out_ready = 1'b0;
        applyStimulus(3, -1, -1);
        applyStimulus(5, -1, -1);
        doReset();
        p_out_ready = 1'b1;
        idle(4);
        applyStimulus(9, 9, 9);
        idle(3);

        loadRotorI();
        for (int i = 0; i < 500; i++) begin
            p_reset     = ($urandom % 200) == 0;
            p_out_ready = ($urandom % 4) != 0;
            p_valid     = ($urandom % 3) != 0;
            p_data      = (($urandom % 12) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
            p_ring      = (($urandom % 16) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
            p_step      = ($urandom % 4) == 0;
            p_pos_load  = ($urandom % 10) == 0;
            p_pos_value = int'($urandom_range(0, 31));
            p_notch     = int'($urandom_range(0, 25));
            p_cfg_we    = ($urandom % 8) == 0;
            p_cfg_addr  = int'($urandom_range(0, 31));
            p_cfg_data  = int'($urandom_range(0, 31));
            cycleStep();
        end

        p_reset = 1'b0; p_valid = 1'b0; p_out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (q_fwd.size() == 0 && q_rev.size() == 0) break;
            cycleStep();
        end
        checkVal("drain_remaining", q_fwd.size() + q_rev.size(), 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
